sw_alloc_out: RTL and testbench

Per-output-port switch allocator for the 5x5 router. It arbitrates among the five input ports that request this output and drives the one-hot select of that output's crossbar mux. The grant is held from head flit to tail flit (wormhole lock). Per-downstream-VC credit counters gate every flit transfer.
There is one instance per output port, placed between the input VC buffers and the crossbar.

---
 rtl/sw_alloc_out_if.sv | 25 ++
 rtl/sw_alloc_out.sv | 180 ++++++++++++++++++
 tb/tb_sw_alloc_out.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sw_alloc_out_if.sv
// Allocator-side bundle for one router output port: per-input requests, crossbar
// select/grant back to the inputs, and the downstream credit return path.
interface sw_alloc_out_if #(
    parameter int NPORT = 5,
    parameter int VCW   = 2
);
    logic [NPORT-1:0]     req;
    logic [NPORT*VCW-1:0] req_vc;
    logic [NPORT-1:0]     req_tail;
    logic                 credit_ret;
    logic [VCW-1:0]       credit_ret_vc;
    logic [NPORT-1:0]     sel;
    logic [NPORT-1:0]     grant;
    logic                 credit_err;

    modport master (
        output req, req_vc, req_tail, credit_ret, credit_ret_vc,
        input  sel, grant, credit_err
    );

    modport slave (
        input  req, req_vc, req_tail, credit_ret, credit_ret_vc,
        output sel, grant, credit_err
    );
endinterface

// File: rtl/sw_alloc_out.sv
// Per-output switch allocator: round-robin arbitration, wormhole lock head-to-tail,
// per-VC credit gating. Optional SW_ALLOC_PERF_CNT_EN adds flit/stall counters.
module sw_alloc_out #(
    parameter int NPORT     = 5,
    parameter int NUM_VC    = 4,
    parameter int VCW       = 2,
    parameter int BUF_DEPTH = 4,
    parameter int CRW       = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    sw_alloc_out_if.slave    bus
`ifdef SW_ALLOC_PERF_CNT_EN
    ,
    output logic [15:0]      perf_flits,
    output logic [15:0]      perf_stall
`endif
);
    localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t                state_reg, state_next;
    logic [PW-1:0]         owner_reg, owner_next;
    logic [VCW-1:0]        lock_vc_reg, lock_vc_next;
    logic [NPORT-1:0]      sel_reg, sel_next;
    logic [PW-1:0]         rr_ptr_reg, rr_ptr_next;
    logic                  credit_err_reg;
    logic [NPORT-1:0]      grant_int;
    logic [NPORT-1:0]      elig;
    logic [NUM_VC-1:0]     credit_nz;
    logic [NUM_VC-1:0]     ovf;
    logic [NUM_VC*CRW-1:0] credit_flat;
    logic                  found;
    logic [PW-1:0]         winner;
    logic [PW:0]           cand;
    logic                  transfer;
    logic                  tail_done;

    genvar gi;

    assign bus.sel        = sel_reg;
    assign bus.grant      = grant_int;
    assign bus.credit_err = credit_err_reg;

    // The owner's flit moves only while it is presented and its locked VC has room.
    assign transfer  = (state_reg == LOCKED) && bus.req[owner_reg] && credit_nz[lock_vc_reg];
    assign tail_done = transfer && bus.req_tail[owner_reg];

    for (gi = 0; gi < NUM_VC; gi++) begin : g_credit
        logic [CRW-1:0] cnt_reg;
        logic           dec;
        logic           inc;

        assign dec = transfer && (lock_vc_reg == VCW'(gi));
        assign inc = bus.credit_ret && (bus.credit_ret_vc == VCW'(gi));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_reg <= CRW'(BUF_DEPTH);
            end else if (dec && !inc) begin
                cnt_reg <= cnt_reg - CRW'(1);
            end else if (inc && !dec && (cnt_reg != CRW'(BUF_DEPTH))) begin
                cnt_reg <= cnt_reg + CRW'(1);
            end
        end

        assign ovf[gi] = inc && !dec && (cnt_reg == CRW'(BUF_DEPTH));
        assign credit_flat[gi*CRW +: CRW] = cnt_reg;
        assign credit_nz[gi] = |credit_flat[gi*CRW +: CRW];
    end

    for (gi = 0; gi < NPORT; gi++) begin : g_elig
        assign elig[gi] = bus.req[gi] && credit_nz[bus.req_vc[gi*VCW +: VCW]];
    end

    // First eligible input at or after rr_ptr, wrapping modulo NPORT.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = 0; k < NPORT; k++) begin
            cand = {1'b0, rr_ptr_reg} + (PW+1)'(k);
            if (cand >= (PW+1)'(NPORT)) begin
                cand = cand - (PW+1)'(NPORT);
            end
            if (!found && elig[cand[PW-1:0]]) begin
                found  = 1'b1;
                winner = cand[PW-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (found)     state_next = LOCKED;
            LOCKED:  if (tail_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        grant_int    = '0;
        sel_next     = sel_reg;
        owner_next   = owner_reg;
        lock_vc_next = lock_vc_reg;
        rr_ptr_next  = rr_ptr_reg;
        case (state_reg)
            IDLE: begin
                sel_next = '0;
                if (found) begin
                    sel_next[winner] = 1'b1;
                    owner_next       = winner;
                    lock_vc_next     = bus.req_vc[winner*VCW +: VCW];
                end
            end
            LOCKED: begin
                if (transfer) begin
                    grant_int = sel_reg;
                end
                // Priority moves only when a whole packet has gone through.
                if (tail_done) begin
                    sel_next    = '0;
                    rr_ptr_next = (owner_reg == PW'(NPORT-1)) ? '0 : owner_reg + PW'(1);
                end
            end
            default: sel_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_reg        <= '0;
            owner_reg      <= '0;
            lock_vc_reg    <= '0;
            rr_ptr_reg     <= '0;
            credit_err_reg <= 1'b0;
        end else begin
            sel_reg        <= sel_next;
            owner_reg      <= owner_next;
            lock_vc_reg    <= lock_vc_next;
            rr_ptr_reg     <= rr_ptr_next;
            credit_err_reg <= credit_err_reg | (|ovf);
        end
    end

`ifdef SW_ALLOC_PERF_CNT_EN
    logic [15:0] perf_flits_reg;
    logic [15:0] perf_stall_reg;
    logic        stall_cyc;

    assign stall_cyc = (state_reg == LOCKED) && bus.req[owner_reg] && !credit_nz[lock_vc_reg];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_flits_reg <= '0;
            perf_stall_reg <= '0;
        end else begin
            if (transfer && (perf_flits_reg != 16'hFFFF)) begin
                perf_flits_reg <= perf_flits_reg + 16'd1;
            end
            if (stall_cyc && (perf_stall_reg != 16'hFFFF)) begin
                perf_stall_reg <= perf_stall_reg + 16'd1;
            end
        end
    end

    assign perf_flits = perf_flits_reg;
    assign perf_stall = perf_stall_reg;
`endif
endmodule

// File: tb/tb_sw_alloc_out.sv
// Directed bench for sw_alloc_out: arbitration order, wormhole lock, credit gating,
// credit overflow and asynchronous reset mid-packet.
module tb_sw_alloc_out;
    localparam int NPORT = 5;
    localparam int VCW   = 2;
    localparam int CRW   = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   passed = 0;
    int   total  = 0;

    sw_alloc_out_if #(.NPORT(NPORT), .VCW(VCW)) bus ();

`ifdef SW_ALLOC_PERF_CNT_EN
    logic [15:0] perf_flits;
    logic [15:0] perf_stall;
`endif

    sw_alloc_out #(
        .NPORT(5), .NUM_VC(4), .VCW(2), .BUF_DEPTH(4), .CRW(3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef SW_ALLOC_PERF_CNT_EN
        ,
        .perf_flits (perf_flits),
        .perf_stall (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.req           = '0;
        bus.req_vc        = '0;
        bus.req_tail      = '0;
        bus.credit_ret    = 1'b0;
        bus.credit_ret_vc = '0;
    endtask

    task automatic apply_reset();
        drive_idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        total++; if (bus.sel !== 5'b0) $display("FAIL rst_sel: got %b expected %b", bus.sel, 5'b0); else passed++;
        total++; if (bus.grant !== 5'b0) $display("FAIL rst_grant: got %b expected %b", bus.grant, 5'b0); else passed++;
        total++; if (bus.credit_err !== 1'b0) $display("FAIL rst_err: got %b expected 0", bus.credit_err); else passed++;
        total++; if (dut.credit_flat !== 12'b100_100_100_100) $display("FAIL rst_credits: got %b expected %b", dut.credit_flat, 12'b100_100_100_100); else passed++;
        total++; if (dut.rr_ptr_reg !== 3'd0) $display("FAIL rst_ptr: got %0d expected 0", dut.rr_ptr_reg); else passed++;
        $display("txn reset done");
        next_cycle();
    endtask

    task automatic test_single_flit();
        bus.req      = 5'b00100;
        bus.req_vc   = 10'b00_0001_0000;
        bus.req_tail = 5'b00100;
        @(negedge clk);
        total++; if (bus.grant !== 5'b0) $display("FAIL sf_arb_grant: got %b expected %b", bus.grant, 5'b0); else passed++;
        next_cycle();
        @(negedge clk);
        total++; if (bus.sel !== 5'b00100) $display("FAIL sf_sel: got %b expected %b", bus.sel, 5'b00100); else passed++;
        total++; if (bus.grant !== 5'b00100) $display("FAIL sf_grant: got %b expected %b", bus.grant, 5'b00100); else passed++;
        next_cycle();
        bus.req           = '0;
        bus.req_tail      = '0;
        bus.credit_ret    = 1'b1;
        bus.credit_ret_vc = 2'd1;
        @(negedge clk);
        total++; if (bus.sel !== 5'b0) $display("FAIL sf_release_sel: got %b expected %b", bus.sel, 5'b0); else passed++;
        total++; if (dut.rr_ptr_reg !== 3'd3) $display("FAIL sf_ptr: got %0d expected 3", dut.rr_ptr_reg); else passed++;
        total++; if (dut.credit_flat[1*CRW +: CRW] !== 3'd3) $display("FAIL sf_credit1: got %0d expected 3", dut.credit_flat[1*CRW +: CRW]); else passed++;
        next_cycle();
        bus.credit_ret = 1'b0;
        @(negedge clk);
        total++; if (dut.credit_flat[1*CRW +: CRW] !== 3'd4) $display("FAIL sf_credit1_ret: got %0d expected 4", dut.credit_flat[1*CRW +: CRW]); else passed++;
        total++; if (bus.credit_err !== 1'b0) $display("FAIL sf_err: got %b expected 0", bus.credit_err); else passed++;
        $display("txn single-flit packet input 2 vc 1");
        next_cycle();
    endtask

    task automatic test_round_robin();
        logic [4:0] exp_oh;
        apply_reset();
        bus.req      = 5'b11111;
        bus.req_vc   = '0;
        bus.req_tail = 5'b11111;
        for (int p = 0; p < 6; p++) begin
            bus.credit_ret    = (p > 0);
            bus.credit_ret_vc = 2'd0;
            @(negedge clk);
            total++; if (bus.grant !== 5'b0) $display("FAIL rr_arb_grant p%0d: got %b expected %b", p, bus.grant, 5'b0); else passed++;
            next_cycle();
            bus.credit_ret = 1'b0;
            exp_oh = 5'b00001 << (p % 5);
            @(negedge clk);
            total++; if (bus.sel !== exp_oh) $display("FAIL rr_sel p%0d: got %b expected %b", p, bus.sel, exp_oh); else passed++;
            total++; if (bus.grant !== exp_oh) $display("FAIL rr_grant p%0d: got %b expected %b", p, bus.grant, exp_oh); else passed++;
            $display("txn rr packet %0d granted %b", p, bus.grant);
            next_cycle();
        end
        bus.req        = '0;
        bus.req_tail   = '0;
        bus.credit_ret = 1'b1;
        next_cycle();
        bus.credit_ret = 1'b0;
        @(negedge clk);
        total++; if (dut.credit_flat[0 +: CRW] !== 3'd4) $display("FAIL rr_credit0: got %0d expected 4", dut.credit_flat[0 +: CRW]); else passed++;
        total++; if (bus.credit_err !== 1'b0) $display("FAIL rr_err: got %b expected 0", bus.credit_err); else passed++;
        total++; if (dut.rr_ptr_reg !== 3'd1) $display("FAIL rr_ptr: got %0d expected 1", dut.rr_ptr_reg); else passed++;
        next_cycle();
    endtask

    task automatic test_wormhole();
        logic [4:0] g_exp [11] = '{5'd0, 5'd2, 5'd2, 5'd2, 5'd2, 5'd0, 5'd0, 5'd0, 5'd2, 5'd2, 5'd0};
        logic [4:0] s_exp [11] = '{5'd0, 5'd2, 5'd2, 5'd2, 5'd2, 5'd2, 5'd2, 5'd2, 5'd2, 5'd2, 5'd0};
        logic       ret   [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        apply_reset();
        bus.req_vc = 10'b00_0000_1000;
        for (int c = 0; c < 11; c++) begin
            bus.req           = (c < 10) ? 5'b01110 : 5'b00000;
            bus.req_tail      = (c == 9) ? 5'b00010 : 5'b00000;
            bus.credit_ret    = ret[c];
            bus.credit_ret_vc = 2'd2;
            @(negedge clk);
            total++; if (bus.grant !== g_exp[c]) $display("FAIL wh_grant c%0d: got %b expected %b", c, bus.grant, g_exp[c]); else passed++;
            total++; if (bus.sel !== s_exp[c]) $display("FAIL wh_sel c%0d: got %b expected %b", c, bus.sel, s_exp[c]); else passed++;
            $display("txn wormhole cycle %0d sel %b grant %b", c, bus.sel, bus.grant);
            if (c < 10) next_cycle();
        end
        total++; if (dut.rr_ptr_reg !== 3'd2) $display("FAIL wh_ptr: got %0d expected 2", dut.rr_ptr_reg); else passed++;
        total++; if (dut.credit_flat[2*CRW +: CRW] !== 3'd0) $display("FAIL wh_credit2: got %0d expected 0", dut.credit_flat[2*CRW +: CRW]); else passed++;
`ifdef SW_ALLOC_PERF_CNT_EN
        total++; if (perf_flits !== 16'd6) $display("FAIL wh_perf_flits: got %0d expected 6", perf_flits); else passed++;
        total++; if (perf_stall !== 16'd3) $display("FAIL wh_perf_stall: got %0d expected 3", perf_stall); else passed++;
`endif
        next_cycle();
        drive_idle();
    endtask

    task automatic test_credit_collision();
        apply_reset();
        bus.req    = 5'b00001;
        bus.req_vc = 10'b00_0000_0001;
        @(negedge clk);
        total++; if (bus.grant !== 5'b0) $display("FAIL cc_arb_grant: got %b expected %b", bus.grant, 5'b0); else passed++;
        for (int c = 1; c <= 3; c++) begin
            next_cycle();
            bus.req_tail      = (c == 3) ? 5'b00001 : 5'b00000;
            bus.credit_ret    = (c == 3);
            bus.credit_ret_vc = 2'd1;
            @(negedge clk);
            total++; if (bus.grant !== 5'b00001) $display("FAIL cc_grant c%0d: got %b expected %b", c, bus.grant, 5'b00001); else passed++;
        end
        total++; if (dut.credit_flat[1*CRW +: CRW] !== 3'd2) $display("FAIL cc_credit1_pre: got %0d expected 2", dut.credit_flat[1*CRW +: CRW]); else passed++;
        next_cycle();
        bus.req           = '0;
        bus.req_tail      = '0;
        bus.credit_ret    = 1'b1;
        bus.credit_ret_vc = 2'd3;
        @(negedge clk);
        total++; if (dut.credit_flat[1*CRW +: CRW] !== 3'd2) $display("FAIL cc_credit1_same: got %0d expected 2", dut.credit_flat[1*CRW +: CRW]); else passed++;
        total++; if (bus.credit_err !== 1'b0) $display("FAIL cc_err_pre: got %b expected 0", bus.credit_err); else passed++;
        next_cycle();
        bus.credit_ret = 1'b0;
        @(negedge clk);
        total++; if (dut.credit_flat[3*CRW +: CRW] !== 3'd4) $display("FAIL cc_credit3_sat: got %0d expected 4", dut.credit_flat[3*CRW +: CRW]); else passed++;
        total++; if (bus.credit_err !== 1'b1) $display("FAIL cc_err_set: got %b expected 1", bus.credit_err); else passed++;
        repeat (3) next_cycle();
        @(negedge clk);
        total++; if (bus.credit_err !== 1'b1) $display("FAIL cc_err_sticky: got %b expected 1", bus.credit_err); else passed++;
        $display("txn credit collision and overflow done");
        next_cycle();
    endtask

    task automatic test_async_reset();
        bus.req      = 5'b10000;
        bus.req_vc   = '0;
        bus.req_tail = '0;
        next_cycle();
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            total++; if (bus.grant !== 5'b10000) $display("FAIL ar_grant c%0d: got %b expected %b", c, bus.grant, 5'b10000); else passed++;
            next_cycle();
        end
        bus.req = '0;
        @(negedge clk);
        total++; if (bus.sel !== 5'b10000) $display("FAIL ar_bubble_sel: got %b expected %b", bus.sel, 5'b10000); else passed++;
        total++; if (bus.grant !== 5'b0) $display("FAIL ar_bubble_grant: got %b expected %b", bus.grant, 5'b0); else passed++;
        total++; if (dut.credit_flat[0 +: CRW] !== 3'd1) $display("FAIL ar_credit0: got %0d expected 1", dut.credit_flat[0 +: CRW]); else passed++;
        bus.req = 5'b10000;
        #1;
        total++; if (bus.grant !== 5'b10000) $display("FAIL ar_resume_grant: got %b expected %b", bus.grant, 5'b10000); else passed++;
        #1 rst_n = 1'b0;
        #1;
        total++; if (bus.sel !== 5'b0) $display("FAIL ar_async_sel: got %b expected %b", bus.sel, 5'b0); else passed++;
        total++; if (bus.grant !== 5'b0) $display("FAIL ar_async_grant: got %b expected %b", bus.grant, 5'b0); else passed++;
        total++; if (dut.credit_flat !== 12'b100_100_100_100) $display("FAIL ar_async_credits: got %b expected %b", dut.credit_flat, 12'b100_100_100_100); else passed++;
        total++; if (bus.credit_err !== 1'b0) $display("FAIL ar_async_err: got %b expected 0", bus.credit_err); else passed++;
        next_cycle();
        next_cycle();
        rst_n        = 1'b1;
        bus.req      = 5'b10001;
        bus.req_tail = 5'b10001;
        @(negedge clk);
        total++; if (bus.grant !== 5'b0) $display("FAIL ar_rearb_grant: got %b expected %b", bus.grant, 5'b0); else passed++;
        next_cycle();
        @(negedge clk);
        total++; if (bus.sel !== 5'b00001) $display("FAIL ar_rearb_sel: got %b expected %b", bus.sel, 5'b00001); else passed++;
        total++; if (bus.grant !== 5'b00001) $display("FAIL ar_rearb_win: got %b expected %b", bus.grant, 5'b00001); else passed++;
        $display("txn async reset mid-packet, restart winner %b", bus.grant);
        next_cycle();
        drive_idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        drive_idle();
        test_reset();
        test_single_flit();
        test_round_robin();
        test_wormhole();
        test_credit_collision();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
